// File: rtl/boot_loader_writer_if.sv
// Byte-stream input, RAM write port and status flags of the boot loader writer.
// The slave modport is the writer itself; the master side feeds bytes and observes the RAM port.
interface boot_loader_writer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wen;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wen,
        input  waddr,
        input  wdata,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wen,
        output waddr,
        output wdata,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/boot_loader_writer.sv
// Loads the 256 x 32-bit boot RAM from a framed byte stream: MAGIC, length, payload, checksum.
// Payload bytes are packed little-endian into words and written one word per WRITE cycle.
module boot_loader_writer #(
    parameter logic [7:0] MAGIC     = 8'hB0,
    parameter logic [7:0] BASE_ADDR = 8'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    boot_loader_writer_if.slave   bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLen   = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StCsum  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] asm_q, asm_d;
    logic [7:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        accept;

    // WRITE is the only state that stalls the upstream.
    assign bus.in_ready = !rst && (state_q != StWrite);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.wen   = (state_q == StWrite);
    assign bus.waddr = waddr_q;
    assign bus.wdata = wdata_q;
    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = done_q;
    assign bus.error = error_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        error_d    = error_q;

        case (state_q)
            StIdle: begin
                if (accept && bus.in_data == MAGIC) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = StLen;
                end
            end

            StLen: begin
                if (accept) begin
                    // A length of zero wraps to 256 words via cnt_q - 1 == 255 below.
                    cnt_d      = bus.in_data;
                    csum_d     = 8'd0;
                    byte_idx_d = 2'd0;
                    word_idx_d = 8'd0;
                    state_d    = StData;
                end
            end

            StData: begin
                if (accept) begin
                    csum_d     = csum_q + bus.in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wdata_d = {bus.in_data, asm_q};
                        waddr_d = BASE_ADDR + word_idx_q;
                        state_d = StWrite;
                    end else begin
                        asm_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
                    end
                end
            end

            StWrite: begin
                word_idx_d = word_idx_q + 8'd1;
                state_d    = (word_idx_q == cnt_q - 8'd1) ? StCsum : StData;
            end

            StCsum: begin
                if (accept) begin
                    if (bus.in_data == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            word_idx_q <= 8'd0;
            byte_idx_q <= 2'd0;
            csum_q     <= 8'd0;
            asm_q      <= 24'd0;
            waddr_q    <= 8'd0;
            wdata_q    <= 32'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            asm_q      <= asm_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_boot_loader_writer.sv
// Bench for boot_loader_writer: two instances (BASE_ADDR 0x00 and 0xF0) share one byte stream
// and their RAM writes are checked against a frame-level model of the packet format.
module tb_boot_loader_writer;

    localparam logic [7:0] MAGIC = 8'hB0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    boot_loader_writer_if bus0 ();
    boot_loader_writer_if bus1 ();

    assign bus0.in_valid = valid;
    assign bus0.in_data  = data;
    assign bus1.in_valid = valid;
    assign bus1.in_data  = data;

    boot_loader_writer #(.MAGIC(MAGIC), .BASE_ADDR(8'h00)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    boot_loader_writer #(.MAGIC(MAGIC), .BASE_ADDR(8'hF0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
        logic        rdy;
    } wr_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          idx;
    } exp_t;

    wr_t        wr0[$];
    wr_t        wr1[$];
    exp_t       exp0[$];
    exp_t       exp1[$];
    logic       exp_done;
    logic       exp_err;
    int         acc_q[$];
    logic [7:0] stim[$];

    always @(negedge clk) begin
        if (bus0.wen === 1'b1) wr0.push_back('{bus0.waddr, bus0.wdata, cyc, bus0.in_ready});
        if (bus1.wen === 1'b1) wr1.push_back('{bus1.waddr, bus1.wdata, cyc, bus1.in_ready});
    end

    // Frame-level reference: skip to MAGIC, read length, pack words, compare checksum.
    task automatic model();
        int p = 0;
        int n;
        int sum = 0;
        logic [31:0] w;
        exp0.delete();
        exp1.delete();
        while (p < stim.size() && stim[p] != MAGIC) p++;
        p++;
        n = (stim[p] == 8'd0) ? 256 : int'(stim[p]);
        p++;
        for (int i = 0; i < n; i++) begin
            w = 32'd0;
            for (int k = 0; k < 4; k++) begin
                w = w | (32'(stim[p]) << (8 * k));
                sum += int'(stim[p]);
                p++;
            end
            exp0.push_back('{8'(i), w, p - 1});
            exp1.push_back('{8'((240 + i) % 256), w, p - 1});
        end
        exp_done = (stim[p] == 8'(sum % 256));
        exp_err  = !exp_done;
    endtask

    // Called and returning on a falling edge; records the cycle stamp of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget = 0;
        repeat (gap) begin
            valid = 1'b0;
            data  = 8'($urandom);
            @(negedge clk);
        end
        valid = 1'b1;
        data  = b;
        while (bus0.in_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b required 1", bus0.in_ready);
        end
        @(posedge clk);
        #1 acc_q.push_back(cyc);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic run_stim(input int maxgap);
        acc_q.delete();
        wr0.delete();
        wr1.delete();
        foreach (stim[i]) send_byte(stim[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus0.in_ready, bus0.wen, bus0.waddr, bus0.wdata, bus0.busy, bus0.done, bus0.error}
            !== 45'd0 || {bus1.in_ready, bus1.wen, bus1.waddr, bus1.wdata, bus1.busy, bus1.done,
            bus1.error} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b busy=%b waddr=%h required all zero",
                     bus0.in_ready, bus0.busy, bus1.waddr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1 || bus0.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ready=%b busy=%b required ready=1 busy=0",
                     bus0.in_ready, bus0.busy);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        stim = '{8'hB0, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        run_stim(0);
        checks++;
        if (wr0.size() != 1 || wr1.size() != 1) begin
            errors++;
            $display("FAIL single_count got %0d/%0d required 1", wr0.size(), wr1.size());
        end else begin
            checks++;
            if (wr0[0].addr !== 8'h00 || wr0[0].data !== 32'h12345678 || wr1[0].addr !== 8'hF0) begin
                errors++;
                $display("FAIL single_write got %h:%h/%h required 00:12345678/f0",
                         wr0[0].addr, wr0[0].data, wr1[0].addr);
            end
            checks++;
            if (wr0[0].cyc != acc_q[5] || wr0[0].rdy !== 1'b0) begin
                errors++;
                $display("FAIL single_latency got cyc %0d rdy %b required cyc %0d rdy 0",
                         wr0[0].cyc, wr0[0].rdy, acc_q[5]);
            end
        end
        checks++;
        if ({bus0.done, bus0.error, bus0.busy} !== 3'b100) begin
            errors++;
            $display("FAIL single_status got done/err/busy=%b%b%b required 100",
                     bus0.done, bus0.error, bus0.busy);
        end
    endtask

    task automatic test_bad_csum();
        stim = '{8'hB0, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h15};
        run_stim(0);
        checks++;
        if (wr0.size() != 1 || wr0[0].data !== 32'h12345678 || {bus0.done, bus0.error} !== 2'b01)
        begin
            errors++;
            $display("FAIL bad_csum writes=%0d done/err=%b%b required 1 write, 01",
                     wr0.size(), bus0.done, bus0.error);
        end
        stim = '{8'hB0, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        run_stim(0);
        checks++;
        if ({bus0.done, bus0.error, bus1.done, bus1.error} !== 4'b1010) begin
            errors++;
            $display("FAIL recover_after_bad got done/err=%b%b required 10", bus0.done, bus0.error);
        end
    endtask

    task automatic test_garbage();
        stim = '{8'h00, 8'hFF, 8'h13, 8'hB0, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        run_stim(0);
        checks++;
        if (wr0.size() != 1 || wr0[0].addr !== 8'h00 || wr0[0].data !== 32'hDEADBEEF ||
            wr0[0].cyc != acc_q[8] || bus0.done !== 1'b1) begin
            errors++;
            $display("FAIL garbage_frame writes=%0d done=%b required 1 write of deadbeef, done=1",
                     wr0.size(), bus0.done);
        end
    endtask

    task automatic test_full_wrap();
        stim = '{8'hB0, 8'h00};
        for (int i = 0; i < 1024; i++) stim.push_back(8'(i));
        stim.push_back(8'h00);
        model();
        run_stim(0);
        checks++;
        if (wr1.size() != 256 || wr0.size() != 256) begin
            errors++;
            $display("FAIL wrap_count got %0d/%0d required 256", wr0.size(), wr1.size());
        end else begin
            checks++;
            if (wr1[0].addr !== 8'hF0 || wr1[0].data !== 32'h03020100 || wr1[15].addr !== 8'hFF ||
                wr1[16].addr !== 8'h00 || wr1[255].addr !== 8'hEF) begin
                errors++;
                $display("FAIL wrap_addr got first %h:%h last %h required f0:03020100 last ef",
                         wr1[0].addr, wr1[0].data, wr1[255].addr);
            end
            for (int i = 0; i < 256; i++) begin
                checks++;
                if (wr1[i].addr !== exp1[i].addr || wr1[i].data !== exp1[i].data ||
                    wr0[i].addr !== exp0[i].addr || wr1[i].cyc != acc_q[exp1[i].idx]) begin
                    errors++;
                    $display("FAIL wrap_word %0d got %h:%h required %h:%h", i, wr1[i].addr,
                             wr1[i].data, exp1[i].addr, exp1[i].data);
                end
            end
        end
        checks++;
        if ({bus1.done, bus1.error} !== {exp_done, exp_err} || exp_done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_status got done/err=%b%b required 10", bus1.done, bus1.error);
        end
    endtask

    task automatic test_gaps();
        for (int f = 0; f < 8; f++) begin
            int len;
            int sum = 0;
            stim.delete();
            if (f == 0) begin
                stim = '{8'hB0, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
            end else begin
                repeat ($urandom_range(0, 3)) stim.push_back(8'($urandom_range(0, 8'hAF)));
                len = $urandom_range(1, 6);
                stim.push_back(MAGIC);
                stim.push_back(8'(len));
                for (int i = 0; i < 4 * len; i++) begin
                    stim.push_back(($urandom_range(0, 7) == 0) ? MAGIC : 8'($urandom));
                    sum += int'(stim[stim.size() - 1]);
                end
                stim.push_back(8'(sum % 256) ^ (($urandom_range(0, 1) == 1) ? 8'h00 : 8'h5A));
            end
            model();
            run_stim(3);
            checks++;
            if (wr0.size() != exp0.size() || wr1.size() != exp1.size()) begin
                errors++;
                $display("FAIL gaps_count frame %0d got %0d required %0d", f, wr0.size(),
                         exp0.size());
            end else begin
                for (int i = 0; i < exp0.size(); i++) begin
                    checks++;
                    if (wr0[i].addr !== exp0[i].addr || wr0[i].data !== exp0[i].data ||
                        wr1[i].addr !== exp1[i].addr || wr1[i].data !== exp1[i].data ||
                        wr0[i].cyc != acc_q[exp0[i].idx] || wr0[i].rdy !== 1'b0) begin
                        errors++;
                        $display("FAIL gaps_word frame %0d word %0d got %h:%h required %h:%h",
                                 f, i, wr0[i].addr, wr0[i].data, exp0[i].addr, exp0[i].data);
                    end
                end
            end
            checks++;
            if ({bus0.done, bus0.error, bus0.busy} !== {exp_done, exp_err, 1'b0}) begin
                errors++;
                $display("FAIL gaps_status frame %0d got done/err/busy=%b%b%b required %b%b0", f,
                         bus0.done, bus0.error, bus0.busy, exp_done, exp_err);
            end
        end
    endtask

    task automatic test_reset_midframe();
        stim = '{8'hB0, 8'h02, 8'h11, 8'h22};
        run_stim(0);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus0.in_ready, bus0.wen, bus0.waddr, bus0.wdata, bus0.busy, bus0.done, bus0.error}
            !== 45'd0 || {bus1.in_ready, bus1.wen, bus1.waddr, bus1.wdata, bus1.busy, bus1.done,
            bus1.error} !== 45'd0) begin
            errors++;
            $display("FAIL midreset_outputs ready=%b busy=%b wdata=%h required all zero",
                     bus0.in_ready, bus0.busy, bus0.wdata);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (wr0.size() != 0 || wr1.size() != 0 || bus0.busy !== 1'b0 || bus0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_after writes=%0d busy=%b ready=%b required 0 writes busy=0 ready=1",
                     wr0.size(), bus0.busy, bus0.in_ready);
        end
        @(negedge clk);
        stim = '{8'hB0, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        run_stim(0);
        checks++;
        if (wr0.size() != 1 || wr1.size() != 1 || wr0[0].addr !== 8'h00 ||
            wr1[0].addr !== 8'hF0 || wr0[0].data !== 32'h04030201 || bus0.done !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reload writes=%0d done=%b required 1 write of 04030201 done=1",
                     wr0.size(), bus0.done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bad_csum();
        test_garbage();
        test_full_wrap();
        test_gaps();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
